// File: rtl/arb_defs.sv
// Shared definitions for the four-requester round-robin arbiter.
package arb_defs;

  localparam int NUM_REQ = 4;
  localparam int CODE_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc4.sv
// Fixed-priority 4-to-2 encoder: lowest set index wins, valid flags any bit set.
module prio_enc4
  import arb_defs::*;
(
  input  logic [NUM_REQ-1:0] r,
  output logic [CODE_W-1:0]  idx,
  output logic               valid
);

  always_comb begin
    idx   = 2'b00;
    valid = 1'b1;
    if (r[0])      idx = 2'b00;
    else if (r[1]) idx = 2'b01;
    else if (r[2]) idx = 2'b10;
    else if (r[3]) idx = 2'b11;
    else           valid = 1'b0;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter over four requesters with a hold limit per grant.
// Handshake: req is level-sensitive; a grant is visible one cycle after req is sampled in IDLE.
module rr_arbiter_4
  import arb_defs::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                done,
  output logic [NUM_REQ-1:0]  grant,
  output logic [CODE_W-1:0]   grant_code,
  output logic                grant_valid,
  output logic                timeout,
  output state_t              dbg_state
);

  state_t              state;
  logic [CODE_W-1:0]   last;
  logic [CNT_W-1:0]    hold_cnt;
  logic [CODE_W-1:0]   start;
  logic [NUM_REQ-1:0]  rot;
  logic [CODE_W-1:0]   enc_idx;
  logic                enc_valid;
  logic [CODE_W-1:0]   winner;
  logic [CODE_W-1:0]   j;
  logic                owner_req;
  logic                hold_lim;
  logic                release_now;

  assign start = last + 2'd1;

  // rot[i] is the request that sits i places after the previous owner.
  always_comb begin
    rot = '0;
    j   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j      = start + 2'(i);
      rot[i] = req[j];
    end
  end

  prio_enc4 u_enc (
    .r     (rot),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign winner      = start + enc_idx;
  assign owner_req   = req[grant_code];
  assign hold_lim    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign release_now = done || !owner_req || hold_lim;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_code  <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      last        <= 2'b11;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enc_valid) begin
            state       <= ST_BUSY;
            grant       <= 4'b0001 << winner;
            grant_code  <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        ST_BUSY: begin
          if (release_now) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_code  <= '0;
            grant_valid <= 1'b0;
            last        <= grant_code;
            // Only a release forced purely by the hold limit is reported.
            timeout     <= !done && owner_req;
          end else if (hold_cnt != {CNT_W{1'b1}}) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter. It shares one resource (bus, ALU, or output port) among req[3:0].
- Built around a fixed-priority 4-to-2 encoder core: lowest index wins, plus a valid flag. The arbiter rotates the request vector so the core yields a fair grant.
- A granted requester holds the resource until it signals done, drops its request, or a hold timeout expires.
- Sits between requester blocks and the shared datapath mux; grant_code drives the mux select directly.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held before forced release; legal range 1..2^CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i]=1 means requester i wants the resource.
- done  input  1  current owner finishes its transfer; sampled only while grant_valid=1.
- grant  output  4  one-hot grant, registered; all zeros when no owner.
- grant_code  output  2  binary index of current owner, registered; 2'b00 when grant_valid=0.
- grant_valid  output  1  1 while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly released by the hold limit.

Behaviour:
- Reset (rst=1 at an edge) sets: state=IDLE, grant=4'b0000, grant_code=2'b00, grant_valid=0, timeout=0, hold_cnt=0, last=2'b11. With last=3, requester 0 has top priority after reset.
- rst has priority over every other input. Reset mid-grant drops the grant on the same edge, with no timeout pulse.
- Rotation: rot = req rotated right by (last+1) mod 4. The encoder picks the lowest set index k of rot. The winner is (last+1+k) mod 4, in 2-bit wrap-around arithmetic.
- State IDLE: grant outputs are 0.
  - If |req=1, the next edge loads grant/grant_code for the winner, sets grant_valid=1, clears hold_cnt to 0, and moves to BUSY.
  - Latency is one cycle from req sampled to grant visible.
  - If req=0, stay in IDLE.
- State BUSY: owner o=grant_code.
  - Release condition: done=1, or req[o]=0, or hold_cnt==MAX_HOLD-1.
  - On release, the next edge clears grant, grant_code and grant_valid, sets last=o, and returns to IDLE.
  - timeout=1 for that single cycle only if the release was caused by the hold limit alone (done=0 and req[o]=1).
  - Otherwise hold_cnt increments by 1 (saturating, never wraps).
- Minimum one dead cycle (grant=0) between consecutive grants. Back-to-back ownership by different requesters is never visible.
- Requests from non-owners in BUSY are ignored until IDLE. Requests are level-sensitive; there is no latching.
- Same requester re-wins only when it is the sole active request after release.
- MAX_HOLD=1: every grant lasts exactly one cycle; timeout pulses whenever the owner kept req high and did not assert done.
- done while grant_valid=0 has no effect.
- Invariants: grant is one-hot or zero; grant==(4'b0001<<grant_code) whenever grant_valid=1; timeout is never high on two consecutive cycles.

Decomposition:
- Shared package/header (arb_defs) holds:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1;
  - NUM_REQ=4 and the code width 2.
- Sub-module prio_enc4: combinational input [3:0] r, outputs [1:0] idx and valid. Lowest index has highest priority (r[0] gives 00). It is instantiated once on the rotated vector.
- Rotation, FSM, hold counter and output registers live in rr_arbiter_4.

Test Plan:
- Reset then req=4'b1111, done pulsed 2 cycles after each grant → grant order 0,1,2,3,0, each grant followed by exactly one zero-grant cycle.
- After reset, req=4'b0100 held, done=0 → grant=4'b0100 and grant_code=2'b10 one cycle later. Grant stays 8 cycles, then drops with timeout=1 for one cycle and re-grants requester 2 after the gap.
- Owner 1 granted with req=4'b1010; drop req[1] → grant clears next edge with timeout=0, then requester 3 is granted (last=1, rotation starts at 2).
- rst asserted during BUSY with hold_cnt=5 → next edge grant=0, grant_valid=0, timeout=0. With req=4'b1001 after reset release, requester 0 wins.
- req=4'b0000 for 10 cycles and done toggled → grant, grant_valid and timeout stay 0, state stays IDLE.
- MAX_HOLD=1 build, req=4'b0011, done=0 → alternating grants 0,1,0,1 of one cycle each, each with a timeout pulse.
